bldc_commutator: RTL

BLDC_COMMUTATOR -- requirements
Module: bldc_commutator

---
 rtl/bldc_commutator_pkg.sv | 74 +++++++
 rtl/bldc_hall_filter.sv | 84 ++++++++
 rtl/bldc_commutator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bldc_commutator_pkg.sv
// ---------------------------------------------------------------------------
// bldc_commutator_pkg
// Shared BLDC types for the commutator and its hall filter: the hall and
// direction types, the sector type and its invalid code, the FSM state
// enum, the six-step drive table and the hall/sector/pattern helpers.
// Drive pattern bit order throughout is {AH,BH,CH,AL,BL,CL}.
// ---------------------------------------------------------------------------
package bldc_commutator_pkg;

    typedef logic [2:0] hall_states_t;      // {A,B,C}
    typedef logic [2:0] sector_t;            // 0..5, 7 = invalid

    typedef enum logic {
        DIR_CW  = 1'b0,
        DIR_CCW = 1'b1
    } rotation_direction_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEADTIME = 2'd1,
        ST_DRIVE    = 2'd2,
        ST_FAULT    = 2'd3
    } commutator_state_t;

    localparam sector_t SECTOR_INVALID = 3'd7;

    // Clockwise six-step table, one pattern per sector.
    localparam logic [5:0] DRIVE_S0      = 6'b100_010;  // AH + BL
    localparam logic [5:0] DRIVE_S1      = 6'b100_001;  // AH + CL
    localparam logic [5:0] DRIVE_S2      = 6'b010_001;  // BH + CL
    localparam logic [5:0] DRIVE_S3      = 6'b010_100;  // BH + AL
    localparam logic [5:0] DRIVE_S4      = 6'b001_100;  // CH + AL
    localparam logic [5:0] DRIVE_S5      = 6'b001_010;  // CH + BL
    localparam logic [5:0] BRAKE_PATTERN = 6'b000_111;  // all low sides
    localparam logic [5:0] DRIVE_OFF     = 6'b000_000;

    // Map a filtered hall code to its sector; 000 and 111 are impossible codes.
    function automatic sector_t hall_to_sector(input hall_states_t hall);
        sector_t s;
        case (hall)
            3'b101:  s = 3'd0;
            3'b100:  s = 3'd1;
            3'b110:  s = 3'd2;
            3'b010:  s = 3'd3;
            3'b011:  s = 3'd4;
            3'b001:  s = 3'd5;
            default: s = SECTOR_INVALID;
        endcase
        return s;
    endfunction

    // Drive pattern for a sector; CCW reuses the CW pattern three sectors on.
    function automatic logic [5:0] sector_pattern(input sector_t sec,
                                                  input rotation_direction_t dir);
        sector_t    idx;
        logic [5:0] pat;
        if (dir == DIR_CCW) begin
            idx = (sec >= 3'd3) ? (sec - 3'd3) : (sec + 3'd3);
        end else begin
            idx = sec;
        end
        case (idx)
            3'd0:    pat = DRIVE_S0;
            3'd1:    pat = DRIVE_S1;
            3'd2:    pat = DRIVE_S2;
            3'd3:    pat = DRIVE_S3;
            3'd4:    pat = DRIVE_S4;
            3'd5:    pat = DRIVE_S5;
            default: pat = DRIVE_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bldc_hall_filter.sv
// ---------------------------------------------------------------------------
// bldc_hall_filter
// Two-flop synchronizer, stability filter and sector decode for the raw
// hall sensors.
//   pclk          in  clock, rising edge
//   preset        in  synchronous active-high reset
//   hall_values   in  raw asynchronous halls {A,B,C}
//   sector        out registered sector of the filtered hall (7 = invalid)
//   hall_acquired out 1 once a hall value has been accepted since reset;
//                     until then the reset value 000 is only an initial
//                     value, not a measured code
// ---------------------------------------------------------------------------
module bldc_hall_filter
    import bldc_commutator_pkg::*;
#(
    parameter int hall_filter_cycles = 4
) (
    input  logic         pclk,
    input  logic         preset,
    input  hall_states_t hall_values,
    output sector_t      sector,
    output logic         hall_acquired
);

    localparam int FILT_MAX = (hall_filter_cycles < 1) ? 1 : hall_filter_cycles;
    localparam int CNT_W    = $clog2(FILT_MAX + 1);

    hall_states_t     sync1_q, sync2_q;
    hall_states_t     cand_q, cand_d;
    hall_states_t     filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sector_t          sector_q, sector_d;
    logic             acq_q, acq_d;

    // Stability filter: cnt counts consecutive identical synchronized samples,
    // including the sample that first presented the candidate value.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q < CNT_W'(FILT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (cnt_d >= CNT_W'(FILT_MAX)) begin
            filt_d = cand_d;
            acq_d  = 1'b1;
        end else begin
            filt_d = filt_q;
            acq_d  = acq_q;
        end

        sector_d = hall_to_sector(filt_d);
    end

    // Synchronizer, filter and decoded-sector registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            sync1_q  <= 3'b000;
            sync2_q  <= 3'b000;
            cand_q   <= 3'b000;
            cnt_q    <= '0;
            filt_q   <= 3'b000;
            sector_q <= SECTOR_INVALID;
            acq_q    <= 1'b0;
        end else begin
            sync1_q  <= hall_values;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            filt_q   <= filt_d;
            sector_q <= sector_d;
            acq_q    <= acq_d;
        end
    end

    assign sector        = sector_q;
    assign hall_acquired = acq_q;

endmodule

// File: rtl/bldc_commutator.sv
// ---------------------------------------------------------------------------
// bldc_commutator
// Six-step BLDC commutation with dead-time, braking, PWM chopping of the
// high sides and latched hall-fault handling.
//   pclk              in  sole clock, rising edge
//   preset            in  synchronous active-high reset
//   enable            in  1 = run commutation, 0 = all phases off
//   dir               in  requested rotation (CW / CCW)
//   brake             in  1 = all low sides on, high sides off
//   pwm_in            in  high-side chop gate
//   hall_values       in  raw asynchronous halls {A,B,C}
//   fault_clr         in  pulse clearing a latched hall fault
//   phase_enable      out registered {AH,BH,CH,AL,BL,CL}
//   sector            out current sector 0..5, 7 = invalid
//   hall_fault        out latched invalid-hall indication
//   commutation_count out accepted sector changes, wrapping
// ---------------------------------------------------------------------------
module bldc_commutator
    import bldc_commutator_pkg::*;
#(
    parameter int deadtime_cycles    = 8,
    parameter int hall_filter_cycles = 4,
    parameter int count_width        = 16
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic                   enable,
    input  rotation_direction_t    dir,
    input  logic                   brake,
    input  logic                   pwm_in,
    input  hall_states_t           hall_values,
    input  logic                   fault_clr,
    output logic [5:0]             phase_enable,
    output sector_t                sector,
    output logic                   hall_fault,
    output logic [count_width-1:0] commutation_count
);

    localparam int DT_MAX = (deadtime_cycles < 0) ? 0 : deadtime_cycles;
    localparam int DT_W   = (DT_MAX < 1) ? 1 : $clog2(DT_MAX + 1);

    sector_t                sector_s;
    logic                   hall_acq_s;
    logic                   sector_valid_s;
    logic                   fault_cond_s;
    logic [5:0]             target_s;

    commutator_state_t      state_q, state_d;
    logic [DT_W-1:0]        dt_q, dt_d;
    logic [5:0]             tgt_q, tgt_d;
    logic [5:0]             phase_q, phase_d;
    logic                   fault_q, fault_d;
    logic [count_width-1:0] count_q, count_d;
    sector_t                sector_prev_q, sector_prev_d;

    bldc_hall_filter #(
        .hall_filter_cycles(hall_filter_cycles)
    ) u_hall_filter (
        .pclk         (pclk),
        .preset       (preset),
        .hall_values  (hall_values),
        .sector       (sector_s),
        .hall_acquired(hall_acq_s)
    );

    // Target pattern: enable gates everything, brake overrides the sector.
    always_comb begin
        sector_valid_s = (sector_s != SECTOR_INVALID);
        fault_cond_s   = enable && hall_acq_s && !sector_valid_s;
        if (!enable) begin
            target_s = DRIVE_OFF;
        end else if (brake) begin
            target_s = BRAKE_PATTERN;
        end else if (sector_valid_s) begin
            target_s = sector_pattern(sector_s, dir);
        end else begin
            target_s = DRIVE_OFF;
        end
    end

    // FSM next state; fault outranks enable=0, which outranks commutation.
    always_comb begin
        state_d = state_q;
        if (fault_cond_s) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable && sector_valid_s) begin
                        state_d = ST_DEADTIME;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DEADTIME: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if ((target_s == tgt_q) && (dt_q <= DT_W'(1))) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_DEADTIME;
                    end
                end
                ST_DRIVE: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (target_s != tgt_q) begin
                        state_d = ST_DEADTIME;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr && sector_valid_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: phases only in DRIVE, high sides chopped by pwm_in.
    always_comb begin
        if (state_d == ST_DRIVE) begin
            phase_d = {target_s[5:3] & {3{pwm_in}}, target_s[2:0]};
        end else begin
            phase_d = DRIVE_OFF;
        end
        fault_d = (state_d == ST_FAULT);
    end

    // Dead-time counter and latched target; a target change restarts the wait.
    always_comb begin
        tgt_d = tgt_q;
        dt_d  = dt_q;
        if (state_d == ST_DEADTIME) begin
            if ((state_q != ST_DEADTIME) || (target_s != tgt_q)) begin
                dt_d  = DT_W'(DT_MAX);
                tgt_d = target_s;
            end else if (dt_q != '0) begin
                dt_d  = dt_q - DT_W'(1);
                tgt_d = tgt_q;
            end else begin
                dt_d  = dt_q;
                tgt_d = tgt_q;
            end
        end else if (state_d == ST_DRIVE) begin
            dt_d  = '0;
            tgt_d = target_s;
        end else begin
            dt_d  = '0;
            tgt_d = DRIVE_OFF;
        end
    end

    // Commutation counter: counts valid-to-valid sector changes outside FAULT.
    always_comb begin
        sector_prev_d = sector_s;
        if (enable && (state_q != ST_FAULT) && sector_valid_s &&
            (sector_prev_q != SECTOR_INVALID) && (sector_s != sector_prev_q)) begin
            count_d = count_q + count_width'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            dt_q          <= '0;
            tgt_q         <= DRIVE_OFF;
            phase_q       <= DRIVE_OFF;
            fault_q       <= 1'b0;
            count_q       <= '0;
            sector_prev_q <= SECTOR_INVALID;
        end else begin
            dt_q          <= dt_d;
            tgt_q         <= tgt_d;
            phase_q       <= phase_d;
            fault_q       <= fault_d;
            count_q       <= count_d;
            sector_prev_q <= sector_prev_d;
        end
    end

    assign phase_enable      = phase_q;
    assign sector            = sector_s;
    assign hall_fault        = fault_q;
    assign commutation_count = count_q;

endmodule
